fp_systolic_mac_pe: RTL and testbench
=====================================

Name: fp_systolic_mac_pe

Overview:
Parametrised floating-point multiply-accumulate processing element for a 2-D systolic array. The A operand flows west→east and the B operand flows north→south through registered forwarding ports. Each PE accumulates K products, where K is set at runtime, then emits one result with its sticky exception flags. It replaces the free-running PE with counted accumulation, valid tracking, an optional multiplier pipeline stage and result framing.

Parameters:
W_MANTISSA, 8, mantissa width.
W_EXPONENT, 8, exponent width.
W_FP (localparam), W_MANTISSA+W_EXPONENT+1, FP word width.
W_CNT, 8, width of the K length counter.
PIPE_MULT, 1, number of registers after the multiplier (0 or 1).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous reset, active-low
clear  in  1  synchronous flush of the accumulation state
k_len  in  W_CNT  number of products per result; 0 is treated as 1
a_in  in  W_FP  A operand from the west neighbour
a_valid_in  in  1  A operand valid
b_in  in  W_FP  B operand from the north neighbour
b_valid_in  in  1  B operand valid
a_out  out  W_FP  registered A forwarded east
a_valid_out  out  1  registered A valid
b_out  out  W_FP  registered B forwarded south
b_valid_out  out  1  registered B valid
result  out  W_FP  accumulated sum; held until the next result
result_valid  out  1  one-cycle pulse per result
result_flags  out  3  {overflow, underflow, exception}, sticky across the K terms, aligned with result
err_misalign  out  1  sticky; set when exactly one of a_valid_in or b_valid_in is high

Behaviour:
- Reset: every output and internal register is 0, and the FSM is in IDLE.
- Forwarding: a_out/a_valid_out/b_out/b_valid_out register their inputs every cycle with 1-cycle latency. The forwarding path is unaffected by clear.
- Operand accept: a term is accepted when a_valid_in && b_valid_in. If only one valid is high, the operand is dropped and err_misalign is set. err_misalign is cleared only by reset or clear.
- Multiplier: uses the existing FpMult. With PIPE_MULT=1, the product and its flags are registered (prod_valid). With PIPE_MULT=0, they pass through combinationally.
- The adder is the existing FpAdder, kept combinational so that the accumulator feedback completes in a single cycle with no hazard.
- FSM states:
  - IDLE: on prod_valid, latch k_eff = max(k_len,1). Load acc directly with the product; it is not added to +0, which preserves -0. Set cnt=1.
  - IDLE → ACCUM if k_eff>1. If k_eff=1, emit the result directly.
  - ACCUM: on prod_valid, acc <= acc + prod and cnt++. On the last term (cnt==k_eff-1), register result=acc+prod, pulse result_valid, reset cnt to 0 and go to IDLE.
  - ACCUM with no prod_valid: hold state (bubbles allowed).
- Latency: last operand pair at cycle t → result_valid at cycle t+1+PIPE_MULT.
- Flags: the OR of the multiplier and adder flags for every term of the current accumulation. They are copied to result_flags with the result, and the internal copy clears when the next accumulation starts.
- k_len is sampled only at the first term; changing it mid-accumulation has no effect.
- Back-to-back: the first term of the next accumulation may arrive in the cycle after the last term. No bubble is required.
- clear: takes priority over an operand arriving in the same cycle, which is dropped. It zeroes prod_valid, cnt, acc and the internal flags and forces IDLE. result and result_flags are held, and result_valid is 0 in the following cycle.
- Reset mid-accumulation: all state is lost and no partial result is emitted.

Optional Feature:
- Macro FP_PE_SATURATE_EN.
- When defined: if the final sum is ±Inf and the overflow flag is set, result is replaced by ±max-finite (exponent all-ones minus 1, mantissa all-ones). The flags are unchanged.
- When undefined: Inf passes through unmodified.

Decomposition:
- Package fp_pe_pkg contains:
  - typedef fp_flags_t (packed struct: ovf, unf, exc);
  - enum pe_state_t {IDLE, ACCUM};
  - function fp_max_finite(sign) parametrised by the widths;
  - localparam FLAG_W=3.
- Natural sub-module: fp_pe_accum_ctrl, holding the FSM, counter, k_eff latch and flag accumulation. The datapath stays in the top level with the FpMult/FpAdder instances.

Test Plan:
- Defaults, k_len=4, four pairs a=2.0 (0x08000), b=3.0 (0x08080) → one result_valid pulse at t+2 with result=24.0 (0x08380) and flags=0.
- k_len=1, pairs 1.0×4.0 (0x07F00, 0x08100) then 2.0×2.0 back-to-back → two pulses on consecutive cycles, each result 4.0 (0x08100).
- Only a_valid_in high for 1 cycle, then K=2 valid pairs of 1.0×1.0 → err_misalign=1 and result=2.0 (0x08000); the misaligned operand is not counted.
- clear asserted after 2 of 4 terms, then 4 fresh pairs of 1.0×1.0 → a single result of 4.0; err_misalign cleared; a_out still forwarded every cycle.
- k_len=2, a=b=max finite (0x0FEFF) → result_flags.ovf=1. result=+Inf (0x0FF00) without FP_PE_SATURATE_EN, 0x0FEFF with it.
- Reset asserted mid-ACCUM, then a k_len=3 run → all outputs 0 during reset and a correct fresh result afterwards.

Source files
------------

// File: rtl/fp_pe_pkg.sv
// rtl/fp_pe_pkg.sv - shared types, constants and helpers for the systolic FP MAC PE
package fp_pe_pkg;

  localparam int FLAG_W = 3;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic exc;
  } fp_flags_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_t;

  // Largest finite magnitude for the given format: exponent all-ones minus 1, mantissa all-ones
  function automatic logic [63:0] fp_max_finite(input logic sign, input int w_exponent,
                                                input int w_mantissa);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < w_mantissa; i++) v[i] = 1'b1;
    for (int i = 1; i < w_exponent; i++) v[w_mantissa+i] = 1'b1;
    v[w_mantissa+w_exponent] = sign;
    return v;
  endfunction

endpackage

// File: rtl/fp_adder.sv
// rtl/fp_adder.sv - combinational FP adder, round-to-nearest-even, subnormals flushed to zero
module FpAdder import fp_pe_pkg::*; #(
  parameter int W_MANTISSA = 8,
  parameter int W_EXPONENT = 8
) (
  input  logic [W_MANTISSA+W_EXPONENT:0] a,
  input  logic [W_MANTISSA+W_EXPONENT:0] b,
  output logic [W_MANTISSA+W_EXPONENT:0] s,
  output fp_flags_t                      flags
);
  localparam int M  = W_MANTISSA;
  localparam int E  = W_EXPONENT;
  localparam int G  = 3;
  localparam int EW = E + 2;
  localparam logic [E-1:0] EMAX = '1;

  logic         sa, sb, sl, ss, swap;
  logic [E-1:0] ea, eb, el, es, d;
  logic [M-1:0] ma, mb, ml, ms;
  logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [M+G:0]   ml_x, ms_x, ms_sh, ms_al, norm;
  logic [M+G+1:0] sum;
  logic [EW-1:0]  lz, exp_n, exp_r;
  logic [M-1:0]   frac, frac_r;
  logic           guard, sticky, sh_sticky, found;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign a_nan  = (ea == EMAX) && (ma != '0);
  assign b_nan  = (eb == EMAX) && (mb != '0);
  assign a_inf  = (ea == EMAX) && (ma == '0);
  assign b_inf  = (eb == EMAX) && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign swap   = {eb, mb} > {ea, ma};
  assign {sl, el, ml} = swap ? b : a;
  assign {ss, es, ms} = swap ? a : b;
  assign d = el - es;

  // Align the smaller operand, add or subtract, normalise, round, then resolve specials
  always_comb begin
    ml_x  = {1'b1, ml, {G{1'b0}}};
    ms_x  = {1'b1, ms, {G{1'b0}}};
    ms_sh = ms_x >> d;
    sh_sticky = 1'b0;
    for (int i = 0; i <= M + G; i++) begin
      if (i < int'(d)) sh_sticky = sh_sticky | ms_x[i];
    end
    ms_al = {ms_sh[M+G:1], ms_sh[0] | sh_sticky};
    if (sl == ss) sum = {1'b0, ml_x} + {1'b0, ms_al};
    else          sum = {1'b0, ml_x} - {1'b0, ms_al};
    lz    = '0;
    found = 1'b0;
    for (int i = M + G; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = EW'(M + G - i);
        found = 1'b1;
      end
    end
    if (sum[M+G+1]) begin
      norm  = {sum[M+G+1:2], sum[1] | sum[0]};
      exp_n = {2'b00, el} + EW'(1);
    end else begin
      norm  = sum[M+G:0] << lz;
      exp_n = {2'b00, el} - lz;
    end
    frac   = norm[M+G-1:G];
    guard  = norm[G-1];
    sticky = |norm[G-2:0];
    {exp_r, frac_r} = {exp_n, frac} + (EW+M)'(guard & (sticky | frac[0]));
    s     = {sl, exp_r[E-1:0], frac_r};
    flags = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      s         = {1'b0, EMAX, 1'b1, {(M-1){1'b0}}};
      flags.exc = 1'b1;
    end else if (a_inf) begin
      s = a;
    end else if (b_inf) begin
      s = b;
    end else if (a_zero && b_zero) begin
      s = {sa & sb, {(E+M){1'b0}}};
    end else if (a_zero) begin
      s = b;
    end else if (b_zero) begin
      s = a;
    end else if (!norm[M+G]) begin
      s = '0;
    end else if (!exp_r[EW-1] && (exp_r >= {2'b00, EMAX})) begin
      s         = {sl, EMAX, {M{1'b0}}};
      flags.ovf = 1'b1;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      s         = {sl, {(E+M){1'b0}}};
      flags.unf = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mult.sv
// rtl/fp_mult.sv - combinational FP multiplier, round-to-nearest-even, subnormals flushed to zero
module FpMult import fp_pe_pkg::*; #(
  parameter int W_MANTISSA = 8,
  parameter int W_EXPONENT = 8
) (
  input  logic [W_MANTISSA+W_EXPONENT:0] a,
  input  logic [W_MANTISSA+W_EXPONENT:0] b,
  output logic [W_MANTISSA+W_EXPONENT:0] p,
  output fp_flags_t                      flags
);
  localparam int M    = W_MANTISSA;
  localparam int E    = W_EXPONENT;
  localparam int EW   = E + 2;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam logic [E-1:0] EMAX = '1;

  logic         sa, sb, sp;
  logic [E-1:0] ea, eb;
  logic [M-1:0] ma, mb;
  logic         a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [2*M+1:0] prod_raw;
  logic [M-1:0]  frac, frac_r;
  logic          guard, sticky;
  logic [EW-1:0] exp_s, exp_r;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign sp     = sa ^ sb;
  assign a_nan  = (ea == EMAX) && (ma != '0);
  assign b_nan  = (eb == EMAX) && (mb != '0);
  assign a_inf  = (ea == EMAX) && (ma == '0);
  assign b_inf  = (eb == EMAX) && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign prod_raw = {{(M+1){1'b0}}, 1'b1, ma} * {{(M+1){1'b0}}, 1'b1, mb};

  // Normalise the significand product, round, then resolve special operands and range
  always_comb begin
    if (prod_raw[2*M+1]) begin
      frac   = prod_raw[2*M -: M];
      guard  = prod_raw[M];
      sticky = |prod_raw[M-1:0];
    end else begin
      frac   = prod_raw[2*M-1 -: M];
      guard  = prod_raw[M-1];
      sticky = |prod_raw[M-2:0];
    end
    exp_s = {2'b00, ea} + {2'b00, eb} - EW'(BIAS) + EW'(prod_raw[2*M+1]);
    {exp_r, frac_r} = {exp_s, frac} + (EW+M)'(guard & (sticky | frac[0]));
    p     = {sp, exp_r[E-1:0], frac_r};
    flags = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      p         = {1'b0, EMAX, 1'b1, {(M-1){1'b0}}};
      flags.exc = 1'b1;
    end else if (a_inf || b_inf) begin
      p = {sp, EMAX, {M{1'b0}}};
    end else if (a_zero || b_zero) begin
      p = {sp, {(E+M){1'b0}}};
    end else if (!exp_r[EW-1] && (exp_r >= {2'b00, EMAX})) begin
      p         = {sp, EMAX, {M{1'b0}}};
      flags.ovf = 1'b1;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      p         = {sp, {(E+M){1'b0}}};
      flags.unf = 1'b1;
    end
  end

endmodule

// File: rtl/fp_pe_accum_ctrl.sv
// rtl/fp_pe_accum_ctrl.sv - accumulation FSM, term counter, k latch and sticky flag tracking
module fp_pe_accum_ctrl import fp_pe_pkg::*; #(
  parameter int W_CNT = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic [W_CNT-1:0] k_len,
  input  logic             prod_valid,
  input  fp_flags_t        mult_flags,
  input  fp_flags_t        add_flags,
  output logic             acc_load,
  output logic             acc_add,
  output logic             emit,
  output logic             in_accum,
  output fp_flags_t        final_flags
);
  pe_state_t        state, next_state;
  logic [W_CNT-1:0] cnt, k_eff, k_now;
  fp_flags_t        acc_flags, term_flags;

  assign in_accum = (state == ACCUM);

  // Next state, datapath strobes and the flag set the current term would close with
  always_comb begin
    next_state = state;
    acc_load   = 1'b0;
    acc_add    = 1'b0;
    emit       = 1'b0;
    term_flags = mult_flags;
    k_now      = (k_len == '0) ? W_CNT'(1) : k_len;
    if (state == ACCUM) term_flags = fp_flags_t'(mult_flags | add_flags);
    if (!clear && prod_valid) begin
      case (state)
        IDLE: begin
          if (k_now == W_CNT'(1)) emit = 1'b1;
          else begin
            acc_load   = 1'b1;
            next_state = ACCUM;
          end
        end
        ACCUM: begin
          if (cnt == k_eff - W_CNT'(1)) begin
            emit       = 1'b1;
            next_state = IDLE;
          end else begin
            acc_add = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
    final_flags = (state == IDLE) ? term_flags : fp_flags_t'(acc_flags | term_flags);
  end

  // State register plus counter, k latch and running flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      k_eff     <= '0;
      acc_flags <= '0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      acc_flags <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && prod_valid) k_eff <= k_now;
      if (emit) begin
        cnt       <= '0;
        acc_flags <= '0;
      end else if (acc_load) begin
        cnt       <= W_CNT'(1);
        acc_flags <= term_flags;
      end else if (acc_add) begin
        cnt       <= cnt + W_CNT'(1);
        acc_flags <= final_flags;
      end
    end
  end

endmodule

// File: rtl/fp_systolic_mac_pe.sv
// rtl/fp_systolic_mac_pe.sv - systolic FP MAC PE with counted accumulation; FP_PE_SATURATE_EN clamps overflowed Inf
module fp_systolic_mac_pe import fp_pe_pkg::*; #(
  parameter int W_MANTISSA = 8,
  parameter int W_EXPONENT = 8,
  parameter int W_CNT      = 8,
  parameter int PIPE_MULT  = 1,
  localparam int W_FP      = W_MANTISSA + W_EXPONENT + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic [W_CNT-1:0]  k_len,
  input  logic [W_FP-1:0]   a_in,
  input  logic              a_valid_in,
  input  logic [W_FP-1:0]   b_in,
  input  logic              b_valid_in,
  output logic [W_FP-1:0]   a_out,
  output logic              a_valid_out,
  output logic [W_FP-1:0]   b_out,
  output logic              b_valid_out,
  output logic [W_FP-1:0]   result,
  output logic              result_valid,
  output logic [FLAG_W-1:0] result_flags,
  output logic              err_misalign
);
  logic            accept, prod_valid, acc_load, acc_add, emit, in_accum;
  logic [W_FP-1:0] mult_p, prod, acc, sum, final_val, result_d;
  fp_flags_t       mult_f, prod_f, add_f, final_flags;

  // A clear in the same cycle as an operand pair wins and drops the pair
  assign accept = a_valid_in & b_valid_in & ~clear;

  // Systolic forwarding; deliberately independent of clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
    end
  end

  // Sticky misalignment: exactly one operand valid means that operand is dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          err_misalign <= 1'b0;
    else if (clear)                     err_misalign <= 1'b0;
    else if (a_valid_in ^ b_valid_in)   err_misalign <= 1'b1;
  end

  FpMult #(.W_MANTISSA(W_MANTISSA), .W_EXPONENT(W_EXPONENT)) u_mult (
    .a(a_in), .b(b_in), .p(mult_p), .flags(mult_f)
  );

  generate
    if (PIPE_MULT != 0) begin : g_pipe
      // Product register splits the multiplier from the accumulate loop
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          prod       <= '0;
          prod_f     <= '0;
          prod_valid <= 1'b0;
        end else begin
          prod_valid <= accept;
          if (accept) begin
            prod   <= mult_p;
            prod_f <= mult_f;
          end
        end
      end
    end else begin : g_comb
      assign prod       = mult_p;
      assign prod_f     = mult_f;
      assign prod_valid = accept;
    end
  endgenerate

  FpAdder #(.W_MANTISSA(W_MANTISSA), .W_EXPONENT(W_EXPONENT)) u_add (
    .a(acc), .b(prod), .s(sum), .flags(add_f)
  );

  fp_pe_accum_ctrl #(.W_CNT(W_CNT)) u_ctrl (
    .clk(clk), .rstn(rstn), .clear(clear), .k_len(k_len), .prod_valid(prod_valid),
    .mult_flags(prod_f), .add_flags(add_f), .acc_load(acc_load), .acc_add(acc_add),
    .emit(emit), .in_accum(in_accum), .final_flags(final_flags)
  );

  // A single-term result is the bare product, so -0 survives
  assign final_val = in_accum ? sum : prod;

`ifdef FP_PE_SATURATE_EN
  logic final_inf;
  assign final_inf = (final_val[W_FP-2 -: W_EXPONENT] == '1) && (final_val[W_MANTISSA-1:0] == '0);
  assign result_d  = (final_inf && final_flags.ovf)
                   ? W_FP'(fp_max_finite(final_val[W_FP-1], W_EXPONENT, W_MANTISSA))
                   : final_val;
`else
  assign result_d = final_val;
`endif

  // Accumulator: first term loads directly, later terms add
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         acc <= '0;
    else if (clear)    acc <= '0;
    else if (acc_load) acc <= prod;
    else if (acc_add)  acc <= sum;
  end

  // Result framing: data and flags held between results, valid pulses once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result       <= '0;
      result_flags <= '0;
      result_valid <= 1'b0;
    end else if (clear) begin
      result_valid <= 1'b0;
    end else begin
      result_valid <= emit;
      if (emit) begin
        result       <= result_d;
        result_flags <= final_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_systolic_mac_pe.sv
// tb/tb_fp_systolic_mac_pe.sv - scoreboard bench for fp_systolic_mac_pe
module tb_fp_systolic_mac_pe;
  localparam int W_FP  = 17;
  localparam int W_CNT = 8;

  localparam logic [W_FP-1:0] F1  = 17'h07F00;
  localparam logic [W_FP-1:0] F2  = 17'h08000;
  localparam logic [W_FP-1:0] F3  = 17'h08080;
  localparam logic [W_FP-1:0] F4  = 17'h08100;
  localparam logic [W_FP-1:0] F18 = 17'h08320;
  localparam logic [W_FP-1:0] F24 = 17'h08380;
  localparam logic [W_FP-1:0] FMX = 17'h0FEFF;
`ifdef FP_PE_SATURATE_EN
  localparam logic [W_FP-1:0] OVF_RES = 17'h0FEFF;
`else
  localparam logic [W_FP-1:0] OVF_RES = 17'h0FF00;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             clear = 1'b0;
  logic [W_CNT-1:0] k_len = '0;
  logic [W_FP-1:0]  a_in = '0, b_in = '0;
  logic             a_valid_in = 1'b0, b_valid_in = 1'b0;
  logic [W_FP-1:0]  a_out, b_out, result;
  logic             a_valid_out, b_valid_out, result_valid, err_misalign;
  logic [2:0]       result_flags;

  typedef struct packed {
    logic [W_FP-1:0] res;
    logic [2:0]      flags;
    logic [31:0]     cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  fp_systolic_mac_pe dut (
    .clk(clk), .rstn(rstn), .clear(clear), .k_len(k_len),
    .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
    .a_out(a_out), .a_valid_out(a_valid_out), .b_out(b_out), .b_valid_out(b_valid_out),
    .result(result), .result_valid(result_valid), .result_flags(result_flags),
    .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_out"}, 32'(a_out), 0);
    check({tag, "_a_valid_out"}, 32'(a_valid_out), 0);
    check({tag, "_b_out"}, 32'(b_out), 0);
    check({tag, "_b_valid_out"}, 32'(b_valid_out), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_result_valid"}, 32'(result_valid), 0);
    check({tag, "_result_flags"}, 32'(result_flags), 0);
    check({tag, "_err_misalign"}, 32'(err_misalign), 0);
  endtask

  // One cycle of stimulus, then confirm the forwarding registers captured it
  task automatic drive(input logic [W_FP-1:0] a, input logic av, input logic [W_FP-1:0] b,
                       input logic bv, input logic clr);
    a_in = a; a_valid_in = av; b_in = b; b_valid_in = bv; clear = clr;
    @(posedge clk); #1;
    check("fwd_a", 32'(a_out), 32'(a));
    check("fwd_a_valid", 32'(a_valid_out), 32'(av));
    check("fwd_b", 32'(b_out), 32'(b));
    check("fwd_b_valid", 32'(b_valid_out), 32'(bv));
    a_valid_in = 1'b0; b_valid_in = 1'b0; clear = 1'b0;
  endtask

  task automatic term(input logic [W_FP-1:0] a, input logic [W_FP-1:0] b, input logic last,
                      input logic [W_FP-1:0] res, input logic [2:0] flags);
    exp_t e;
    if (last) begin
      e.res = res; e.flags = flags; e.cyc = 32'(cyc + 2);
      sb_q.push_back(e);
    end
    drive(a, 1'b1, b, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every result pulse must match the oldest expected entry, in data and timing
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && result_valid) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_result: got 0x%0h expected no result", result);
        end else begin
          mon_e = sb_q.pop_front();
          check("result", 32'(result), 32'(mon_e.res));
          check("result_flags", 32'(result_flags), 32'(mon_e.flags));
          check("result_latency_cycle", 32'(cyc), mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(1);

    // K=4: four 2.0*3.0 terms sum to 24.0; k_len changed mid-run must be ignored
    k_len = 8'd4;
    term(F2, F3, 1'b0, '0, 3'b000);
    term(F2, F3, 1'b0, '0, 3'b000);
    k_len = 8'd1;
    term(F2, F3, 1'b0, '0, 3'b000);
    term(F2, F3, 1'b1, F24, 3'b000);
    idle(3);

    // K=1 back-to-back, second with k_len=0 which behaves as 1
    k_len = 8'd1;
    term(F1, F4, 1'b1, F4, 3'b000);
    k_len = 8'd0;
    term(F2, F2, 1'b1, F4, 3'b000);
    idle(3);

    // Lone A operand is dropped and flagged; then K=2 of 1.0*1.0
    k_len = 8'd2;
    drive(F1, 1'b1, '0, 1'b0, 1'b0);
    check("err_misalign_set", 32'(err_misalign), 1);
    term(F1, F1, 1'b0, '0, 3'b000);
    term(F1, F1, 1'b1, F2, 3'b000);
    idle(3);

    // Clear after two of four terms, with a pair in the clear cycle that must be dropped
    k_len = 8'd4;
    term(F1, F1, 1'b0, '0, 3'b000);
    term(F1, F1, 1'b0, '0, 3'b000);
    drive(F1, 1'b1, F1, 1'b1, 1'b1);
    check("err_misalign_cleared", 32'(err_misalign), 0);
    check("clear_result_held", 32'(result), 32'(F2));
    check("clear_no_valid", 32'(result_valid), 0);
    term(F1, F1, 1'b0, '0, 3'b000);
    term(F1, F1, 1'b0, '0, 3'b000);
    term(F1, F1, 1'b0, '0, 3'b000);
    term(F1, F1, 1'b1, F4, 3'b000);
    idle(3);

    // Overflow: max*max twice gives Inf with ovf set
    k_len = 8'd2;
    term(FMX, FMX, 1'b0, '0, 3'b000);
    term(FMX, FMX, 1'b1, OVF_RES, 3'b100);
    idle(3);

    // Reset in the middle of an accumulation, then a fresh K=3 run
    k_len = 8'd3;
    term(F1, F1, 1'b0, '0, 3'b000);
    term(F1, F1, 1'b0, '0, 3'b000);
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    idle(2);
    rstn = 1'b1;
    term(F2, F3, 1'b0, '0, 3'b000);
    term(F2, F3, 1'b0, '0, 3'b000);
    term(F2, F3, 1'b1, F18, 3'b000);
    idle(4);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
    check("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
